// File: rtl/colour_stream_ctrl.sv
// Frame sequencer for the colour datapath: gates upstream samples, tracks the
// datapath valid bits and stamps each delivered pixel with its (x, y) position.
module colour_stream_ctrl #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        pipe_en,
    input  logic [7:0]  pipe_red,
    input  logic [7:0]  pipe_green,
    input  logic [7:0]  pipe_blue,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [23:0] px_rgb,
    output logic [15:0] px_x,
    output logic [15:0] px_y,
    output logic        px_sof,
    output logic        px_eol
);

    localparam logic [31:0] FRAME_PIX = H_RES[31:0] * V_RES[31:0];
    localparam logic [15:0] X_LAST    = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST    = 16'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                r_state;
    logic                  r_done;
    logic [31:0]           r_acc_cnt;
    logic [PIPE_LAT-1:0]   r_vld;
    logic [15:0]           r_x;
    logic [15:0]           r_y;

    logic                  w_busy;
    logic                  w_pipe_en;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_px_valid;
    logic                  w_px_hs;
    logic                  w_start_go;
    logic                  w_last_px;
    logic [PIPE_LAT:0]     w_vld_shift;

    assign w_busy      = (r_state != IDLE);
    assign w_px_valid  = r_vld[PIPE_LAT-1];
    assign w_pipe_en   = w_busy && (!w_px_valid || px_ready);
    assign w_in_ready  = (r_state == RUN) && w_pipe_en;
    assign w_accept    = in_valid && w_in_ready;
    assign w_px_hs     = w_px_valid && px_ready;
    assign w_start_go  = start && (r_state == IDLE);
    assign w_last_px   = (r_x == X_LAST) && (r_y == Y_LAST);
    // Extra bit lets the shift work unchanged for PIPE_LAT == 1.
    assign w_vld_shift = {r_vld, w_accept};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_acc_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_acc_cnt <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + 32'd1;
                        if (r_acc_cnt == FRAME_PIX - 32'd1)
                            r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_px_hs && w_last_px) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bubbles enter whenever the pipe advances without an accepted sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_vld <= '0;
        else if (w_pipe_en)
            r_vld <= w_vld_shift[PIPE_LAT-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_start_go) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_px_hs) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? 16'd0 : r_y + 16'd1;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign in_ready = w_in_ready;
    assign pipe_en  = w_pipe_en;
    assign px_valid = w_px_valid;
    assign px_rgb   = {pipe_red, pipe_green, pipe_blue};
    assign px_x     = r_x;
    assign px_y     = r_y;
    assign px_sof   = w_px_valid && (r_x == 16'd0) && (r_y == 16'd0);
    assign px_eol   = w_px_valid && (r_x == X_LAST);

endmodule

// File: tb/tb_colour_stream_ctrl.sv
// Directed bench for colour_stream_ctrl with a 3-stage colour datapath model
// and a scoreboard of expected pixels built from the accepted samples.
module tb_colour_stream_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int PL = 3;

    logic        clk = 1'b0;
    logic        resetn, start, busy, done, in_valid, in_ready, pipe_en;
    logic [7:0]  pipe_red, pipe_green, pipe_blue;
    logic        px_valid, px_ready, px_sof, px_eol;
    logic [23:0] px_rgb;
    logic [15:0] px_x, px_y;
    logic [7:0]  in_data;

    colour_stream_ctrl #(.H_RES(H), .V_RES(V), .PIPE_LAT(PL)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .pipe_en(pipe_en),
        .pipe_red(pipe_red), .pipe_green(pipe_green), .pipe_blue(pipe_blue),
        .px_valid(px_valid), .px_ready(px_ready), .px_rgb(px_rgb),
        .px_x(px_x), .px_y(px_y), .px_sof(px_sof), .px_eol(px_eol)
    );

    always #5 clk = ~clk;

    // Stand-in colour datapath: advances only on pipe_en.
    logic [23:0] dp [PL];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PL; i++) dp[i] <= '0;
        end else if (pipe_en) begin
            dp[0] <= {in_data, ~in_data, in_data ^ 8'h5A};
            for (int i = 1; i < PL; i++) dp[i] <= dp[i-1];
        end
    end
    assign {pipe_red, pipe_green, pipe_blue} = dp[PL-1];

    typedef struct { logic [23:0] rgb; logic [15:0] x; logic [15:0] y; } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_push = 0, acc_cnt = 0, px_cnt = 0, stall_cnt = 0, frames_done = 0;
    int first_acc_cyc = 0, first_px_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    int frame_acc = 0, frame_px = 0;
    logic [2:0] acc_hist = '0;
    logic chk_lat = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [23:0] hold_rgb;
    logic [15:0] hold_x, hold_y;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard pop on handshake, push on accept, per-frame bookkeeping.
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            q.delete();
            n_push = 0; acc_cnt = 0; px_cnt = 0;
            acc_hist = '0; prev_stall = 1'b0; prev_done = 1'b0;
        end else begin
            chk("pipe_en_eq", pipe_en, busy && (!px_valid || px_ready));
            chk("in_ready_gate", in_ready && !pipe_en, 0);
            if (chk_lat) chk("vld_latency", px_valid, acc_hist[2]);
            if (prev_stall) begin
                chk("hold_rgb", px_rgb, hold_rgb);
                chk("hold_x", px_x, hold_x);
                chk("hold_y", px_y, hold_y);
            end
            if (px_valid && !px_ready) begin
                stall_cnt++;
                hold_rgb = px_rgb; hold_x = px_x; hold_y = px_y;
            end
            prev_stall = px_valid && !px_ready;
            if (px_valid && px_ready) begin
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("px_rgb", px_rgb, e.rgb);
                    chk("px_x", px_x, e.x);
                    chk("px_y", px_y, e.y);
                    chk("px_sof", px_sof, (e.x == 0) && (e.y == 0));
                    chk("px_eol", px_eol, e.x == H - 1);
                end
                if (px_cnt == 0) first_px_cyc = cyc;
                last_hs_cyc = cyc;
                px_cnt++;
            end
            if (in_valid && in_ready) begin
                e.rgb = {in_data, ~in_data, in_data ^ 8'h5A};
                e.x   = 16'(n_push % H);
                e.y   = 16'((n_push / H) % V);
                q.push_back(e);
                n_push++;
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
            acc_hist = {acc_hist[1:0], in_valid && in_ready};
            if (done) begin
                chk("done_single", prev_done, 0);
                done_cyc = cyc; frame_acc = acc_cnt; frame_px = px_cnt;
                acc_cnt = 0; px_cnt = 0;
                frames_done++;
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        in_data = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input int bound);
        logic got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            tick();
            got = done;
        end
        chk("done_timeout", got, 1);
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, "_acc"}, frame_acc, 8);
        chk({tag, "_px"}, frame_px, 8);
        chk({tag, "_sb_drained"}, q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        resetn = 1'b0; start = 1'b0; in_valid = 1'b0; px_ready = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_sof_eol", {px_sof, px_eol}, 0);
        chk("rst_xy", {px_x, px_y}, 0);
        resetn = 1'b1;
        tick();

        // Frame 1: streaming, latency and throughput.
        in_valid = 1'b1; px_ready = 1'b1; chk_lat = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("f1_busy", busy, 1);
        wait_done(60); tick();
        chk("f1_latency", first_px_cyc - first_acc_cyc, PL);
        chk("f1_consec", last_hs_cyc - first_px_cyc, 7);
        chk("f1_done_lat", done_cyc - last_hs_cyc, 1);
        chk("f1_idle", busy, 0);
        frame_checks("f1");

        // Frame 2: downstream stall of 5 cycles mid-frame.
        chk_lat = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin tick(); got = (px_cnt >= 3); end
        chk("f2_reach_mid", got, 1);
        px_ready = 1'b0;
        begin
            int s0 = stall_cnt;
            repeat (5) tick();
            chk("f2_stall_cycles", stall_cnt - s0, 5);
        end
        px_ready = 1'b1;
        wait_done(60); tick();
        frame_checks("f2");

        // Frame 3: in_valid toggling every cycle.
        chk_lat = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            in_valid = !in_valid; tick(); got = done;
        end
        chk("f3_done_timeout", got, 1);
        in_valid = 1'b1;
        tick();
        chk("f3_spacing", last_hs_cyc - first_px_cyc, 14);
        frame_checks("f3");

        // Frame 4: start pulses while busy are ignored; next start coincides with done.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(60);
        start = 1'b1; tick(); start = 1'b0;
        chk("f4_coinc_busy", busy, 1);
        frame_checks("f4");

        // Frame 5: launched by the coincident start.
        wait_done(60); tick();
        frame_checks("f5");

        // Frame 6: reset after three accepts.
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin tick(); got = (acc_cnt >= 3); end
        chk("f6_three_acc", got, 1);
        chk("f6_pre_rst_valid", px_valid, 1);
        resetn = 1'b0; #1;
        chk("f6_rst_busy", busy, 0);
        chk("f6_rst_done", done, 0);
        chk("f6_rst_ready_en", {in_ready, pipe_en}, 0);
        chk("f6_rst_px_valid", px_valid, 0);
        chk("f6_rst_sof_eol", {px_sof, px_eol}, 0);
        chk("f6_rst_xy", {px_x, px_y}, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Frame 7: clean restart after reset.
        start = 1'b1; tick(); start = 1'b0;
        wait_done(60); tick();
        frame_checks("f7");
        chk("frames_done", frames_done, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colour_stream_ctrl.md
COLOUR_STREAM_CTRL -- requirements
Module: colour_stream_ctrl

Interface
REQ-001 The block SHALL have parameter H_RES, default 640, pixels per line (2..65535).
REQ-002 The block SHALL have parameter V_RES, default 480, lines per frame (1..65535).
REQ-003 The block SHALL have parameter PIPE_LAT, default 3, enabled-cycle latency of the colour datapath (1..8).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have the port start  in  1  one-cycle request to process one frame.
REQ-006 The block SHALL have the port busy  out  1  high while a frame is in progress.
REQ-007 The block SHALL have the port done  out  1  one-cycle pulse after the last pixel of a frame is delivered.
REQ-008 The block SHALL have the port in_valid  in  1  upstream (phase, log_mag) sample valid.
REQ-009 The block SHALL have the port in_ready  out  1  sample accepted this cycle when in_valid is also high.
REQ-010 The block SHALL have the port pipe_en  out  1  advance enable driving the colour datapath ready input.
REQ-011 The block SHALL have the ports pipe_red, pipe_green, pipe_blue  in  8 each  colour datapath outputs.
REQ-012 The block SHALL have the port px_valid  out  1  output pixel valid.
REQ-013 The block SHALL have the port px_ready  in  1  downstream accepts pixel.
REQ-014 The block SHALL have the port px_rgb  out  24  {red,green,blue}, equal to the pipe_* inputs.
REQ-015 The block SHALL have the ports px_x, px_y  out  16 each  coordinates of the current px_rgb.
REQ-016 The block SHALL have the ports px_sof, px_eol  out  1 each  px_x==0&&px_y==0, and px_x==H_RES-1; both qualified by px_valid.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FLUSH; busy SHALL be high iff state != IDLE.
REQ-018 IDLE->RUN SHALL occur on start; start SHALL be ignored outside IDLE.
REQ-019 RUN->FLUSH SHALL occur on the cycle the H_RES*V_RES-th sample is accepted.
REQ-020 FLUSH->IDLE SHALL occur on the handshake of the last pixel (px_x==H_RES-1, px_y==V_RES-1); done SHALL be high the following cycle for exactly one cycle.
REQ-021 pipe_en SHALL be busy && (!px_valid || px_ready), combinational.
REQ-022 in_ready SHALL be (state==RUN) && pipe_en, combinational; a sample is accepted iff in_valid && in_ready.
REQ-023 A PIPE_LAT-bit valid shift register SHALL shift only when pipe_en is high, loading the accept bit at bit 0; px_valid SHALL equal its MSB.
REQ-024 When pipe_en is high and no sample is accepted, a bubble (0) SHALL be inserted; bubbles SHALL never produce px_valid.
REQ-025 While px_valid && !px_ready, pipe_en SHALL be low, and px_rgb/px_x/px_y SHALL be held stable.
REQ-026 px_x SHALL increment on each pixel handshake, wrap from H_RES-1 to 0 and increment px_y; px_y SHALL wrap from V_RES-1 to 0.
REQ-027 An internal accept counter (width 32) SHALL count accepted samples and clear on entry to RUN.
REQ-028 Throughput SHALL be one pixel per cycle when in_valid and px_ready are held high; sample-to-pixel latency SHALL be PIPE_LAT cycles.
REQ-029 When start is asserted on the same cycle as done, start SHALL be honoured, because state is IDLE on that cycle.

Reset
REQ-030 On resetn low the block SHALL asynchronously force state=IDLE, the valid shift register to 0, the counters to 0, and busy, done, in_ready, pipe_en, px_valid, px_sof and px_eol to 0.
REQ-031 Reset mid-frame SHALL discard in-flight samples with no done pulse; the next start SHALL begin at px_x=0, px_y=0.

Verification
REQ-032 Scenario: H_RES=4, V_RES=2, PIPE_LAT=3, start, in_valid and px_ready held high -> first px_valid 3 cycles after the first accept; 8 pixels on consecutive cycles; px_eol on x=3; done 1 cycle after the 8th handshake.
REQ-033 Scenario: px_ready low for 5 cycles mid-frame -> pipe_en and in_ready low; px_rgb, px_x and px_y stable; no pixel lost or duplicated.
REQ-034 Scenario: in_valid toggling 1,0,1,0 -> px_valid follows the same pattern delayed by 3 cycles; coordinates increment only on valid handshakes.
REQ-035 Scenario: start pulsed while busy -> ignored; the accept count stays at 8 per frame.
REQ-036 Scenario: resetn low after 3 accepts -> all outputs 0 immediately; a new start produces px_sof on the first pixel and no stale pixels.
REQ-037 Scenario: start coincident with done -> the second frame starts without an idle cycle; px_sof appears on its first pixel.
